mem_if: RTL and testbench

MEM_IF -- requirements
Module: mem_if

---
 rtl/mem_if_pkg.sv | 20 ++
 rtl/mem_if_if.sv | 34 +++
 rtl/mem_if_io.sv | 49 ++++
 rtl/mem_if.sv | 114 +++++++++++
 tb/tb_mem_if.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared I/O address map and FSM state encoding for mem_if
package mem_if_pkg;

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] USER_BASE = 16'h3000;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_io_addr(input logic [15:0] addr);
        return addr >= IO_BASE;
    endfunction

endpackage

// File: rtl/mem_if_if.sv
// rtl/mem_if_if.sv - datapath, external memory and keyboard signals of mem_if
interface mem_if_if;
    logic [15:0] bus;
    logic        ld_mar;
    logic        ld_mdr;
    logic        ld_acv;
    logic        mio_en;
    logic        r_w;
    logic        psr_15;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        ready;
    logic        acv;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        run;

    modport slave (
        input  bus, ld_mar, ld_mdr, ld_acv, mio_en, r_w, psr_15,
        input  mem_rdata, mem_ack, kbd_valid, kbd_data,
        output mar, mdr, ready, acv, bus_err, mem_req, mem_we, run
    );

    modport master (
        output bus, ld_mar, ld_mdr, ld_acv, mio_en, r_w, psr_15,
        output mem_rdata, mem_ack, kbd_valid, kbd_data,
        input  mar, mdr, ready, acv, bus_err, mem_req, mem_we, run
    );
endinterface

// File: rtl/mem_if_io.sv
// rtl/mem_if_io.sv - memory-mapped keyboard status/data and machine control registers
module mem_if_io
    import mem_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    input  logic        kbd_valid_i,
    input  logic [7:0]  kbd_data_i,
    output logic [15:0] rdata_o,
    output logic        run_o
);
    logic        kbsr_q;
    logic [7:0]  kbdr_q;
    logic [15:0] mcr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr_q <= 1'b0;
            kbdr_q <= 8'h00;
            mcr_q  <= 16'h8000;
        end else begin
            // A new keystroke takes priority over the clear caused by reading KBDR
            if (kbd_valid_i) begin
                kbsr_q <= 1'b1;
                kbdr_q <= kbd_data_i;
            end else if (rd_en_i && addr_i == KBDR_ADDR) begin
                kbsr_q <= 1'b0;
            end
            if (wr_en_i && addr_i == MCR_ADDR)
                mcr_q <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = 16'h0000;
        case (addr_i)
            KBSR_ADDR: rdata_o = {kbsr_q, 15'h0000};
            KBDR_ADDR: rdata_o = {8'h00, kbdr_q};
            MCR_ADDR:  rdata_o = mcr_q;
            default:   rdata_o = 16'h0000;
        endcase
    end

    assign run_o = mcr_q[15];
endmodule

// File: rtl/mem_if.sv
// rtl/mem_if.sv - MAR/MDR memory interface with external bus, timeout and internal I/O
module mem_if
    import mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_if_if.slave   mif
);
    state_e      state_q, state_d;
    logic [15:0] mar_q, mdr_q, mdr_d, cnt_q, cnt_d;
    logic        we_q, we_d, err_q, err_d, acv_q;
    logic        done_entry, io_rd, io_wr, timeout_hit;
    logic [15:0] rd_data, io_rdata;

    // Counter holds EXT cycles already waited; expiry after TIMEOUT cycles without ack
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        err_d      = err_q;
        done_entry = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        rd_data    = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (mif.mio_en) begin
                    we_d  = mif.r_w;
                    err_d = 1'b0;
                    if (is_io_addr(mar_q)) begin
                        state_d    = ST_DONE;
                        done_entry = 1'b1;
                        io_rd      = !mif.r_w;
                        io_wr      = mif.r_w;
                        rd_data    = io_rdata;
                    end else begin
                        state_d = ST_EXT;
                        cnt_d   = 16'h0000;
                    end
                end
            end
            ST_EXT: begin
                if (mif.mem_ack) begin
                    state_d    = ST_DONE;
                    done_entry = 1'b1;
                    rd_data    = mif.mem_rdata;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    done_entry = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        mdr_d = mdr_q;
        if (mif.ld_mdr) begin
            if (!mif.mio_en)
                mdr_d = mif.bus;
            else if (done_entry && !we_d)
                mdr_d = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
            cnt_q   <= 16'h0000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            acv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            if (mif.ld_mar)
                mar_q <= mif.bus;
            if (mif.ld_acv)
                acv_q <= mif.psr_15 & ((mif.bus < USER_BASE) | (mif.bus >= IO_BASE));
        end
    end

    mem_if_io u_io (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_i     (mar_q),
        .wdata_i    (mdr_q),
        .wr_en_i    (io_wr),
        .rd_en_i    (io_rd),
        .kbd_valid_i(mif.kbd_valid),
        .kbd_data_i (mif.kbd_data),
        .rdata_o    (io_rdata),
        .run_o      (mif.run)
    );

    assign mif.mar     = mar_q;
    assign mif.mdr     = mdr_q;
    assign mif.acv     = acv_q;
    assign mif.ready   = (state_q == ST_DONE);
    assign mif.bus_err = (state_q == ST_DONE) && err_q;
    assign mif.mem_req = (state_q == ST_EXT);
    assign mif.mem_we  = (state_q == ST_EXT) && we_q;
endmodule

// File: tb/tb_mem_if.sv
// tb/tb_mem_if.sv - directed self-checking bench for mem_if
module tb_mem_if;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_if_if mif ();

    mem_if #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mif  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_mar(input logic [15:0] v);
        @(negedge clk);
        mif.bus = v; mif.ld_mar = 1'b1;
        @(negedge clk);
        mif.ld_mar = 1'b0;
    endtask

    task automatic set_mdr(input logic [15:0] v);
        @(negedge clk);
        mif.bus = v; mif.ld_mdr = 1'b1; mif.mio_en = 1'b0;
        @(negedge clk);
        mif.ld_mdr = 1'b0;
    endtask

    // Single-cycle internal I/O access from IDLE; ready is checked one cycle later
    task automatic io_access(input logic [15:0] addr, input logic wr, input string name);
        set_mar(addr);
        mif.mio_en = 1'b1; mif.r_w = wr; mif.ld_mdr = !wr;
        @(negedge clk);
        checks++; if (mif.ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b expected 1", name, mif.ready); end
        checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL %s mem_req: got %b expected 0", name, mif.mem_req); end
        mif.mio_en = 1'b0; mif.ld_mdr = 1'b0; mif.r_w = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mif.mar !== 16'h0000) begin errors++; $display("FAIL reset mar: got %h expected 0000", mif.mar); end
        checks++; if (mif.mdr !== 16'h0000) begin errors++; $display("FAIL reset mdr: got %h expected 0000", mif.mdr); end
        checks++; if ({mif.ready, mif.acv, mif.bus_err, mif.mem_req, mif.mem_we} !== 5'b0) begin errors++; $display("FAIL reset flags: got %b expected 00000", {mif.ready, mif.acv, mif.bus_err, mif.mem_req, mif.mem_we}); end
        checks++; if (mif.run !== 1'b1) begin errors++; $display("FAIL reset run: got %b expected 1", mif.run); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read;
        set_mar(16'h3000);
        mif.mio_en = 1'b1; mif.r_w = 1'b0; mif.ld_mdr = 1'b1;
        @(negedge clk);
        checks++; if ({mif.mem_req, mif.mem_we} !== 2'b10) begin errors++; $display("FAIL read req/we: got %b expected 10", {mif.mem_req, mif.mem_we}); end
        @(negedge clk);
        @(negedge clk);
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'h1234;
        checks++; if (mif.ready !== 1'b0) begin errors++; $display("FAIL read early ready: got %b expected 0", mif.ready); end
        @(negedge clk);
        mif.mem_ack = 1'b0;
        checks++; if ({mif.ready, mif.bus_err} !== 2'b10) begin errors++; $display("FAIL read ready/bus_err: got %b expected 10", {mif.ready, mif.bus_err}); end
        checks++; if (mif.mdr !== 16'h1234) begin errors++; $display("FAIL read mdr: got %h expected 1234", mif.mdr); end
        mif.mio_en = 1'b0; mif.ld_mdr = 1'b0;
        @(negedge clk);
        checks++; if (mif.ready !== 1'b0) begin errors++; $display("FAIL read ready pulse width: got %b expected 0", mif.ready); end
    endtask

    task automatic test_write;
        set_mar(16'h4000);
        set_mdr(16'hBEEF);
        mif.mio_en = 1'b1; mif.r_w = 1'b1;
        @(negedge clk);
        mif.r_w = 1'b0;
        checks++; if ({mif.mem_req, mif.mem_we} !== 2'b11) begin errors++; $display("FAIL write req/we: got %b expected 11", {mif.mem_req, mif.mem_we}); end
        @(negedge clk);
        checks++; if ({mif.mem_req, mif.mem_we, mif.ready} !== 3'b110) begin errors++; $display("FAIL write held: got %b expected 110", {mif.mem_req, mif.mem_we, mif.ready}); end
        mif.mem_ack = 1'b1; mif.mem_rdata = 16'h5555;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        checks++; if ({mif.ready, mif.bus_err, mif.mem_req} !== 3'b100) begin errors++; $display("FAIL write done: got %b expected 100", {mif.ready, mif.bus_err, mif.mem_req}); end
        checks++; if (mif.mdr !== 16'hBEEF) begin errors++; $display("FAIL write mdr: got %h expected beef", mif.mdr); end
        checks++; if (mif.mar !== 16'h4000) begin errors++; $display("FAIL write mar: got %h expected 4000", mif.mar); end
        mif.mio_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        set_mar(16'h5000);
        mif.mio_en = 1'b1; mif.r_w = 1'b0; mif.ld_mdr = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if ({mif.mem_req, mif.ready} !== 2'b10) begin errors++; $display("FAIL timeout last wait: got %b expected 10", {mif.mem_req, mif.ready}); end
        @(negedge clk);
        checks++; if ({mif.ready, mif.bus_err} !== 2'b11) begin errors++; $display("FAIL timeout ready/bus_err: got %b expected 11", {mif.ready, mif.bus_err}); end
        checks++; if (mif.mdr !== 16'h0000) begin errors++; $display("FAIL timeout mdr: got %h expected 0000", mif.mdr); end
        mif.mio_en = 1'b0; mif.ld_mdr = 1'b0;
        @(negedge clk);
        checks++; if ({mif.ready, mif.bus_err} !== 2'b00) begin errors++; $display("FAIL timeout after: got %b expected 00", {mif.ready, mif.bus_err}); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] seen;
        set_mdr(16'h7777);
        set_mar(16'h3000);
        mif.mio_en = 1'b1; mif.r_w = 1'b0; mif.mem_ack = 1'b1; mif.mem_rdata = 16'hA5A5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen[i] = mif.ready;
        end
        mif.mio_en = 1'b0; mif.mem_ack = 1'b0;
        checks++; if (seen !== 5'b10010) begin errors++; $display("FAIL b2b ready sequence: got %b expected 10010", seen); end
        checks++; if (mif.mdr !== 16'h7777) begin errors++; $display("FAIL b2b mdr no ld: got %h expected 7777", mif.mdr); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_acv;
        logic [15:0] bv  [6] = '{16'h2FFF, 16'h4000, 16'h2FFF, 16'hFE00, 16'h3000, 16'hFDFF};
        logic        pv  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        lv  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        exp [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            mif.bus = bv[i]; mif.psr_15 = pv[i]; mif.ld_acv = lv[i];
            @(negedge clk);
            mif.ld_acv = 1'b0;
            checks++; if (mif.acv !== exp[i]) begin errors++; $display("FAIL acv vec%0d bus=%h: got %b expected %b", i, bv[i], mif.acv, exp[i]); end
        end
        mif.psr_15 = 1'b0;
    endtask

    task automatic test_keyboard;
        mif.kbd_valid = 1'b1; mif.kbd_data = 8'h41;
        @(negedge clk);
        mif.kbd_valid = 1'b0;
        io_access(16'hFE00, 1'b0, "kbsr_rd");
        checks++; if (mif.mdr !== 16'h8000) begin errors++; $display("FAIL kbsr set: got %h expected 8000", mif.mdr); end
        io_access(16'hFE02, 1'b0, "kbdr_rd");
        checks++; if (mif.mdr !== 16'h0041) begin errors++; $display("FAIL kbdr data: got %h expected 0041", mif.mdr); end
        io_access(16'hFE00, 1'b0, "kbsr_clr");
        checks++; if (mif.mdr !== 16'h0000) begin errors++; $display("FAIL kbsr cleared: got %h expected 0000", mif.mdr); end
        mif.kbd_valid = 1'b1; mif.kbd_data = 8'h42;
        @(negedge clk);
        mif.kbd_valid = 1'b0;
        set_mar(16'hFE02);
        mif.mio_en = 1'b1; mif.r_w = 1'b0; mif.ld_mdr = 1'b1;
        mif.kbd_valid = 1'b1; mif.kbd_data = 8'h43;
        @(negedge clk);
        mif.kbd_valid = 1'b0; mif.mio_en = 1'b0; mif.ld_mdr = 1'b0;
        checks++; if (mif.mdr !== 16'h0042) begin errors++; $display("FAIL kbdr race data: got %h expected 0042", mif.mdr); end
        @(negedge clk);
        io_access(16'hFE00, 1'b0, "kbsr_race");
        checks++; if (mif.mdr !== 16'h8000) begin errors++; $display("FAIL kbsr set wins: got %h expected 8000", mif.mdr); end
        set_mdr(16'hFFFF);
        io_access(16'hFE04, 1'b0, "unmapped_rd");
        checks++; if (mif.mdr !== 16'h0000) begin errors++; $display("FAIL unmapped read: got %h expected 0000", mif.mdr); end
        io_access(16'hFFFE, 1'b1, "mcr_wr");
        checks++; if (mif.run !== 1'b0) begin errors++; $display("FAIL mcr run clear: got %b expected 0", mif.run); end
    endtask

    task automatic test_reset_mid;
        set_mar(16'h3000);
        mif.mio_en = 1'b1; mif.r_w = 1'b1;
        @(negedge clk);
        checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL mid pre mem_req: got %b expected 1", mif.mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mif.mem_req, mif.mem_we} !== 2'b00) begin errors++; $display("FAIL mid reset mem_req/we: got %b expected 00", {mif.mem_req, mif.mem_we}); end
        checks++; if (mif.run !== 1'b1) begin errors++; $display("FAIL mid reset run: got %b expected 1", mif.run); end
        mif.mem_ack = 1'b1;
        @(negedge clk);
        mif.mem_ack = 1'b0; mif.mio_en = 1'b0; mif.r_w = 1'b0;
        checks++; if (mif.ready !== 1'b0) begin errors++; $display("FAIL mid reset ready: got %b expected 0", mif.ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({mif.ready, mif.mem_req, mif.mar} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL post reset idle: got %b/%h expected 00/0000", {mif.ready, mif.mem_req}, mif.mar); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        mif.bus = 16'h0; mif.ld_mar = 1'b0; mif.ld_mdr = 1'b0; mif.ld_acv = 1'b0;
        mif.mio_en = 1'b0; mif.r_w = 1'b0; mif.psr_15 = 1'b0;
        mif.mem_rdata = 16'h0; mif.mem_ack = 1'b0; mif.kbd_valid = 1'b0; mif.kbd_data = 8'h0;
        test_reset;
        test_read;
        test_write;
        test_timeout;
        test_back_to_back;
        test_acv;
        test_keyboard;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
